// File: rtl/y86_alu_pkg.sv
// Shared Y86 ALU definitions: word width, condition-code bundle, result-buffer state.
package y86_alu_pkg;

   localparam int WORD_W = 64;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Y86 condition codes derived from a subtraction result and its overflow bit.
   function automatic cc_t cc_from_diff(input logic [WORD_W-1:0] diff, input logic ovf);
      cc_t cc;
      cc.zf = (diff == {WORD_W{1'b0}});
      cc.sf = diff[WORD_W-1];
      cc.of = ovf;
      return cc;
   endfunction

endpackage

// File: rtl/alu_subtractor_64.sv
// Combinational 64-bit two's-complement subtractor with signed-overflow detect.
module alu_subtractor_64
   import y86_alu_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] difference,
   output logic              overflow
);

   assign difference = a - b;
   // Overflow only when operand signs differ and the result sign departs from a.
   assign overflow   = (a[WORD_W-1] ^ b[WORD_W-1]) & (difference[WORD_W-1] ^ a[WORD_W-1]);

endmodule

// File: rtl/alu_sub_arbiter_64.sv
// Round-robin arbiter sharing one alu_subtractor_64 between two requesters,
// with a single tagged result buffer and per-port valid/ready handshakes.
module alu_sub_arbiter_64
   import y86_alu_pkg::*;
#(
   parameter int WIDTH = WORD_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_diff,
   output logic             resp0_of,
   output logic             resp0_zf,
   output logic             resp0_sf,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_diff,
   output logic             resp1_of,
   output logic             resp1_zf,
   output logic             resp1_sf,
   output logic             busy
);

   state_e           state_q, state_d;
   logic             tag_q, tag_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   cc_t              cc_q, cc_d;

   logic             drain_s;
   logic             can_accept_s;
   logic             grant0_s;
   logic             grant1_s;
   logic             accept_s;
   logic [WIDTH-1:0] sub_a_s;
   logic [WIDTH-1:0] sub_b_s;
   logic [WIDTH-1:0] sub_diff_s;
   logic             sub_ovf_s;

   // Grant: a lone requester wins; on a tie the port not granted last wins.
   always_comb begin
      drain_s = 1'b0;
      if (state_q == ST_FULL) begin
         drain_s = tag_q ? resp1_ready : resp0_ready;
      end else begin
         drain_s = 1'b0;
      end
      can_accept_s = ~reset & ((state_q == ST_EMPTY) | drain_s);
      grant0_s     = can_accept_s & req0_valid & (~req1_valid |  last_grant_q);
      grant1_s     = can_accept_s & req1_valid & (~req0_valid | ~last_grant_q);
      accept_s     = grant0_s | grant1_s;
      sub_a_s      = grant1_s ? req1_a : req0_a;
      sub_b_s      = grant1_s ? req1_b : req0_b;
   end

   alu_subtractor_64 u_sub (
      .a          (sub_a_s),
      .b          (sub_b_s),
      .difference (sub_diff_s),
      .overflow   (sub_ovf_s)
   );

   // Buffer next state: an accept overwrites even while draining, so no bubble.
   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      last_grant_d = last_grant_q;
      diff_d       = diff_q;
      cc_d         = cc_q;
      if (accept_s) begin
         state_d      = ST_FULL;
         tag_d        = grant1_s;
         last_grant_d = grant1_s;
         diff_d       = sub_diff_s;
         cc_d         = cc_from_diff(sub_diff_s, sub_ovf_s);
      end else if (drain_s) begin
         state_d      = ST_EMPTY;
      end else begin
         state_d      = state_q;
      end
   end

   // State, buffer and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         tag_q        <= 1'b0;
         last_grant_q <= 1'b1;
         diff_q       <= {WIDTH{1'b0}};
         cc_q         <= '{zf: 1'b0, sf: 1'b0, of: 1'b0};
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         last_grant_q <= last_grant_d;
         diff_q       <= diff_d;
         cc_q         <= cc_d;
      end
   end

   assign req0_ready  = grant0_s;
   assign req1_ready  = grant1_s;
   assign busy        = (state_q == ST_FULL);
   assign resp0_valid = (state_q == ST_FULL) & ~tag_q;
   assign resp1_valid = (state_q == ST_FULL) &  tag_q;
   assign resp0_diff  = diff_q;
   assign resp1_diff  = diff_q;
   assign resp0_zf    = cc_q.zf;
   assign resp1_zf    = cc_q.zf;
   assign resp0_sf    = cc_q.sf;
   assign resp1_sf    = cc_q.sf;
   assign resp0_of    = cc_q.of;
   assign resp1_of    = cc_q.of;

endmodule

// File: tb/tb_alu_sub_arbiter_64.sv
// Bench for alu_sub_arbiter_64: directed scenarios plus random traffic against a
// transaction-level model of the arbiter and result buffer.
module tb_alu_sub_arbiter_64;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [63:0] resp0_diff, resp1_diff;
   logic        resp0_of, resp0_zf, resp0_sf, resp1_of, resp1_zf, resp1_sf;
   logic        busy;

   always #5 clk = ~clk;

   alu_sub_arbiter_64 dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_diff(resp0_diff),
      .resp0_of(resp0_of), .resp0_zf(resp0_zf), .resp0_sf(resp0_sf),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_diff(resp1_diff),
      .resp1_of(resp1_of), .resp1_zf(resp1_zf), .resp1_sf(resp1_sf),
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one optional pending result with an owner, plus tie pointer.
   logic        m_known = 1'b0;
   logic        m_full, m_owner, m_last, m_zf, m_sf, m_of;
   logic [63:0] m_diff;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Which port should win this cycle: -1 none, else 0/1.
   function automatic int model_winner(input logic rst, input logic v0, input logic v1,
                                       input logic r0, input logic r1);
      logic room;
      room = !m_full || (m_owner ? r1 : r0);
      if (rst || !room) return -1;
      if (v0 && v1)     return m_last ? 0 : 1;
      if (v0)           return 0;
      if (v1)           return 1;
      return -1;
   endfunction

   task automatic cycle(input logic rst,
                        input logic v0, input logic [63:0] a0, input logic [63:0] b0,
                        input logic v1, input logic [63:0] a1, input logic [63:0] b1,
                        input logic r0, input logic r1,
                        output logic g0, output logic g1);
      int w;
      logic signed [64:0] wide;
      @(negedge clk);
      reset = rst; req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1; resp0_ready = r0; resp1_ready = r1;
      #1;
      g0 = req0_ready;
      g1 = req1_ready;
      if (m_known) begin
         w = model_winner(rst, v0, v1, r0, r1);
         chk("req0_ready", {63'd0, req0_ready}, {63'd0, (w == 0)});
         chk("req1_ready", {63'd0, req1_ready}, {63'd0, (w == 1)});
         chk("busy", {63'd0, busy}, {63'd0, m_full});
         chk("resp0_valid", {63'd0, resp0_valid}, {63'd0, m_full && !m_owner});
         chk("resp1_valid", {63'd0, resp1_valid}, {63'd0, m_full && m_owner});
         if (m_full) begin
            chk("diff", m_owner ? resp1_diff : resp0_diff, m_diff);
            chk("flags", {61'd0, m_owner ? {resp1_zf, resp1_sf, resp1_of}
                                         : {resp0_zf, resp0_sf, resp0_of}},
                {61'd0, m_zf, m_sf, m_of});
         end
      end else begin
         w = -1;
      end
      @(posedge clk);
      if (rst) begin
         m_known = 1'b1; m_full = 1'b0; m_owner = 1'b0; m_last = 1'b1;
         m_diff = 64'd0; m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
      end else if (m_known) begin
         if (w >= 0) begin
            wide = (w == 1) ? ($signed({a1[63], a1}) - $signed({b1[63], b1}))
                            : ($signed({a0[63], a0}) - $signed({b0[63], b0}));
            m_full  = 1'b1;
            m_owner = (w == 1);
            m_last  = (w == 1);
            m_diff  = wide[63:0];
            m_of    = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
            m_zf    = (m_diff == 64'd0);
            m_sf    = ($signed(m_diff) < 0);
         end else if (m_full && (m_owner ? r1 : r0)) begin
            m_full = 1'b0;
         end
      end
   endtask

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 64'h0000_0000_0000_0000;
         1:       return 64'h8000_0000_0000_0000;
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         3:       return 64'hFFFF_FFFF_FFFF_FFFF;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   initial begin
      logic g0, g1, v0, v1, p0, p1, r0, r1;
      logic [63:0] a0, b0, a1, b1;
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 64'd0; req0_b = 64'd0; req1_a = 64'd0; req1_b = 64'd0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;

      // Single port
      cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_valid", {62'd0, resp0_valid, resp1_valid}, 64'd0);
      chk("rst_diff", resp0_diff, 64'd0);
      cycle(1'b0, 1'b1, -64'sd456, -64'sd154, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      chk("single_rdy", {63'd0, g0}, 64'd1);
      #1;
      chk("single_valid", {63'd0, resp0_valid}, 64'd1);
      chk("single_diff", resp0_diff, -64'sd302);
      chk("single_flags", {61'd0, resp0_zf, resp0_sf, resp0_of}, 64'd2);

      // Tie alternation from reset
      cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 1'b1, 64'sd25620, -64'sd5264, 1'b1, 64'sd58974, -64'sd254781,
               1'b1, 1'b1, g0, g1);
         chk("tie_g0", {63'd0, g0}, {63'd0, (k % 2 == 0)});
         chk("tie_g1", {63'd0, g1}, {63'd0, (k % 2 == 1)});
         #1;
         chk("tie_diff", (k % 2 == 0) ? resp0_diff : resp1_diff,
             (k % 2 == 0) ? 64'd30884 : 64'd313755);
      end

      // Zero result on port 1
      cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'hABCD_ABCD_ABCD_ABCD, 64'hABCD_ABCD_ABCD_ABCD,
            1'b1, 1'b1, g0, g1);
      #1;
      chk("zero_valid", {62'd0, resp0_valid, resp1_valid}, 64'd1);
      chk("zero_diff", resp1_diff, 64'd0);
      chk("zero_flags", {61'd0, resp1_zf, resp1_sf, resp1_of}, 64'd4);

      // Overflow corners
      cycle(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      #1;
      chk("ovf1_diff", resp0_diff, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("ovf1_flags", {61'd0, resp0_zf, resp0_sf, resp0_of}, 64'd1);
      cycle(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 64'd0,
            1'b1, 1'b1, g0, g1);
      #1;
      chk("ovf2_diff", resp0_diff, 64'h8000_0000_0000_0000);
      chk("ovf2_flags", {61'd0, resp0_zf, resp0_sf, resp0_of}, 64'd3);

      // Back-pressure
      cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      cycle(1'b0, 1'b1, 64'd9, 64'd4, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd100, 64'd1, 1'b0, 1'b1, g0, g1);
         chk("bp_g1", {63'd0, g1}, 64'd0);
         #1;
         chk("bp_hold", {resp0_valid, resp0_diff[62:0]}, {1'b1, 63'd5});
      end
      cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 64'd100, 64'd1, 1'b1, 1'b1, g0, g1);
      chk("bp_release", {63'd0, g1}, 64'd1);
      #1;
      chk("bp_resp1", {62'd0, resp0_valid, resp1_valid}, 64'd1);
      chk("bp_diff", resp1_diff, 64'd99);

      // Reset mid-operation
      cycle(1'b0, 1'b1, 64'd7, 64'd2, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, g0, g1);
      cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, g0, g1);
      #1;
      chk("mid_rst", {62'd0, resp0_valid, busy}, 64'd0);
      cycle(1'b0, 1'b1, 64'd3, 64'd1, 1'b1, 64'd8, 64'd1, 1'b1, 1'b1, g0, g1);
      chk("mid_tie", {62'd0, g0, g1}, 64'd2);

      // Random traffic; a requester keeps operands stable until accepted
      p0 = 1'b0; p1 = 1'b0;
      a0 = 64'd0; b0 = 64'd0; a1 = 64'd0; b1 = 64'd0;
      for (int i = 0; i < 600; i++) begin
         v0 = p0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) != 0);
         v1 = p1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) != 0);
         if (!(p0 && v0)) begin
            a0 = rnd_op(); b0 = ($urandom_range(0, 7) == 0) ? a0 : rnd_op();
         end
         if (!(p1 && v1)) begin
            a1 = rnd_op(); b1 = ($urandom_range(0, 7) == 0) ? a1 : rnd_op();
         end
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         cycle(($urandom_range(0, 99) == 0), v0, a0, b0, v1, a1, b1, r0, r1, g0, g1);
         p0 = v0 && !g0;
         p1 = v1 && !g1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
